// File: rtl/load_store_unit_pkg.sv
// Shared memory-access types for the load/store unit.
// Size codes follow the RISC-V load/store funct3 field.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic lsu_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic size_ok;
    logic algn_ok;
    size_ok = 1'b0;
    algn_ok = 1'b0;
    case (size)
      MEM_B: begin
        size_ok = 1'b1;
        algn_ok = 1'b1;
      end
      MEM_H: begin
        size_ok = 1'b1;
        algn_ok = ~off[0];
      end
      MEM_W: begin
        size_ok = 1'b1;
        algn_ok = (off == 2'b00);
      end
      // unsigned sizes exist only for loads
      MEM_BU: begin
        size_ok = rd;
        algn_ok = 1'b1;
      end
      MEM_HU: begin
        size_ok = rd;
        algn_ok = ~off[0];
      end
      default: ;
    endcase
    return (rd ^ wr) & size_ok & algn_ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, store replication and
// load extract/extend. Purely combinational.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [31:0] sh;

  assign sh = rword >> {off, 3'b000};

  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    rext  = 32'h0;
    case (size)
      MEM_B: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
        rext  = {{24{sh[7]}}, sh[7:0]};
      end
      MEM_BU: begin
        be    = 4'b0001 << off;
        wlane = {4{wdata[7:0]}};
        rext  = {24'h0, sh[7:0]};
      end
      MEM_H: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        rext  = {{16{sh[15]}}, sh[15:0]};
      end
      MEM_HU: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wlane = {2{wdata[15:0]}};
        rext  = {16'h0, sh[15:0]};
      end
      MEM_W: begin
        be    = 4'b1111;
        rext  = sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-cycle-core load/store unit: one valid/ready word-bus
// transaction per access, stalling the core until done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              lsu_fault,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_be,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t    state;
  bus_req_t      q;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   rdata_q;
  logic          fault_q;

  logic        access;
  logic        legal;
  logic        in_idle;
  logic [2:0]  a_size;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wlane;
  logic [31:0] a_rext;

  assign access  = mem_read | mem_write;
  assign legal   = lsu_legal(mem_read, mem_write,
                             mem_size, addr[1:0]);
  assign in_idle = (state == IDLE);
  assign cnt_nxt = cnt + 1'b1;

  // one aligner: live inputs in IDLE, latched ones afterwards
  assign a_size = in_idle ? mem_size  : size_q;
  assign a_off  = in_idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .size  (a_size),
    .off   (a_off),
    .wdata (wdata),
    .rword (resp_rdata),
    .be    (a_be),
    .wlane (a_wlane),
    .rext  (a_rext)
  );

  assign req_valid = (state == REQ);
  assign req_we    = q.we;
  assign req_addr  = ADDR_W'(q.addr);
  assign req_be    = q.be;
  assign req_wdata = q.wdata;

  assign stall = (state == REQ) | (state == WAIT_RESP)
               | (in_idle & access & legal);
  assign rdata = (state == DONE) ? rdata_q : 32'h0;
  assign lsu_fault = (state == DONE) ? fault_q
                   : (in_idle & access & ~legal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      cnt     <= '0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          rdata_q <= 32'h0;
          fault_q <= 1'b0;
          if (access & legal) begin
            q.we    <= mem_write;
            q.addr  <= 32'({addr[ADDR_W-1:2], 2'b00});
            q.be    <= a_be;
            q.wdata <= a_wlane;
            size_q  <= mem_size;
            off_q   <= addr[1:0];
            state   <= REQ;
          end
        end
        REQ: begin
          if (req_ready) state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          cnt <= cnt_nxt;
          if (resp_valid) begin
            rdata_q <= q.we ? 32'h0 : a_rext;
            fault_q <= 1'b0;
            state   <= DONE;
          end else if (TIMEOUT_CYCLES != 0 &&
                       cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random accesses against a byte-arithmetic model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, lsu_fault;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .lsu_fault  (lsu_fault),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic rd, input logic wr,
                                 input int sz, input logic [31:0] a);
    bit ok;
    if (rd == wr) return 0;
    ok = (sz == 0 || sz == 1 || sz == 2) ||
         (rd && (sz == 4 || sz == 5));
    if ((sz == 1 || sz == 5) && (a % 2 != 0)) ok = 0;
    if (sz == 2 && (a % 4 != 0)) ok = 0;
    return ok;
  endfunction

  function automatic logic [3:0] m_be(input int sz,
                                      input logic [31:0] a);
    int o = int'(a % 4);
    if (sz == 0 || sz == 4) return 4'(1 << o);
    if (sz == 1 || sz == 5) return 4'(3 << o);
    return 4'hf;
  endfunction

  function automatic logic [31:0] m_wd(input int sz,
                                       input logic [31:0] d);
    if (sz == 0) return (d & 32'hff) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hffff) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rd(input int sz,
                                       input logic [31:0] a,
                                       input logic [31:0] r);
    logic [31:0] v, b;
    v = r >> (8 * (a % 4));
    case (sz)
      0: begin
        b = v & 32'hff;
        return (b >= 128) ? b - 32'd256 : b;
      end
      4: return v & 32'hff;
      1: begin
        b = v & 32'hffff;
        return (b >= 32768) ? b - 32'd65536 : b;
      end
      5: return v & 32'hffff;
      default: return r;
    endcase
  endfunction

  task automatic do_access(input string tag,
                           input logic rd, input logic wr,
                           input int sz, input logic [31:0] a,
                           input logic [31:0] wd,
                           input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rword);
    bit tout;
    @(negedge clk);
    mem_read = rd; mem_write = wr;
    mem_size = 3'(sz); addr = a; wdata = wd;
    #1;
    if (!m_legal(rd, wr, sz, a)) begin
      chk({tag, ".fault"}, 32'(lsu_fault), 1);
      chk({tag, ".stall"}, 32'(stall), 0);
      chk({tag, ".rdata"}, rdata, 0);
      @(negedge clk);
      chk({tag, ".novalid"}, 32'(req_valid), 0);
      mem_read = 0; mem_write = 0;
      #1;
      chk({tag, ".fault_clr"}, 32'(lsu_fault), 0);
      return;
    end
    chk({tag, ".stall0"}, 32'(stall), 1);
    chk({tag, ".fault0"}, 32'(lsu_fault), 0);
    chk({tag, ".valid0"}, 32'(req_valid), 0);
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      req_ready = (i == rdy_dly);
      #1;
      chk({tag, ".req_valid"}, 32'(req_valid), 1);
      chk({tag, ".req_stall"}, 32'(stall), 1);
      chk({tag, ".req_addr"}, req_addr, a & ~32'h3);
      chk({tag, ".req_be"}, 32'(req_be), 32'(m_be(sz, a)));
      chk({tag, ".req_we"}, 32'(req_we), 32'(wr));
      if (wr) chk({tag, ".req_wdata"}, req_wdata, m_wd(sz, wd));
      chk({tag, ".req_rdata"}, rdata, 0);
    end
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      req_ready  = 0;
      resp_valid = (w == rsp_dly);
      resp_rdata = (w == rsp_dly) ? rword : $urandom;
      #1;
      chk({tag, ".wait_valid"}, 32'(req_valid), 0);
      chk({tag, ".wait_stall"}, 32'(stall), 1);
      if (w == rsp_dly) break;
    end
    tout = (rsp_dly > 3);
    @(negedge clk);
    resp_valid = 0;
    #1;
    chk({tag, ".done_stall"}, 32'(stall), 0);
    chk({tag, ".done_fault"}, 32'(lsu_fault), 32'(tout));
    chk({tag, ".done_rdata"}, rdata,
        (tout || wr) ? 32'h0 : m_rd(sz, a, rword));
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    #1;
    chk({tag, ".idle_stall"}, 32'(stall), 0);
    chk({tag, ".idle_rdata"}, rdata, 0);
    chk({tag, ".idle_valid"}, 32'(req_valid), 0);
  endtask

  initial begin
    logic        rd, wr;
    int          sz;
    logic [31:0] a;
    int          lsz[5] = '{0, 1, 2, 4, 5};

    rst = 1; mem_read = 0; mem_write = 0; mem_size = 0;
    addr = 0; wdata = 0; req_ready = 0;
    resp_valid = 0; resp_rdata = 0;
    #1;
    chk("rst.valid", 32'(req_valid), 0);
    chk("rst.we", 32'(req_we), 0);
    chk("rst.be", 32'(req_be), 0);
    chk("rst.addr", req_addr, 0);
    chk("rst.wdata", req_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.fault", 32'(lsu_fault), 0);
    chk("rst.stall", 32'(stall), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    do_access("lw", 1, 0, 2, 32'h100, 0, 0, 0, 32'hDEAD_BEEF);
    do_access("lb", 1, 0, 0, 32'h103, 0, 0, 0, 32'h80FF_FF7F);
    do_access("lbu", 1, 0, 4, 32'h103, 0, 0, 0, 32'h80FF_FF7F);
    do_access("sh", 0, 1, 1, 32'h202, 32'h1234_ABCD, 0, 0, 0);
    do_access("lw_mis", 1, 0, 2, 32'h101, 0, 0, 0, 0);
    do_access("rdwr", 1, 1, 2, 32'h100, 0, 0, 0, 0);
    do_access("sz011", 1, 0, 3, 32'h100, 0, 0, 0, 0);
    do_access("sbu", 0, 1, 4, 32'h100, 0, 0, 0, 0);
    do_access("rdy5", 1, 0, 1, 32'h42, 0, 5, 1, 32'h1234_8765);
    do_access("tmo", 1, 0, 2, 32'h80, 0, 0, 10, 32'h5555_AAAA);

    // reset while a load waits for its response
    @(negedge clk);
    mem_read = 1; mem_size = 2; addr = 32'h40;
    @(negedge clk);
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    #1;
    chk("mid.stall", 32'(stall), 1);
    rst = 1; mem_read = 0;
    #1;
    chk("mid.valid", 32'(req_valid), 0);
    chk("mid.stall0", 32'(stall), 0);
    chk("mid.be", 32'(req_be), 0);
    chk("mid.addr", req_addr, 0);
    chk("mid.rdata", rdata, 0);
    @(negedge clk);
    rst = 0; resp_valid = 1; resp_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late.stall", 32'(stall), 0);
    chk("late.rdata", rdata, 0);
    @(negedge clk);
    resp_valid = 0;
    #1;
    chk("late.rdata2", rdata, 0);
    chk("late.fault", 32'(lsu_fault), 0);
    chk("late.valid", 32'(req_valid), 0);
    do_access("lhu", 1, 0, 5, 32'h10, 0, 0, 0, 32'h0000_F00D);

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ~rd;
      sz = rd ? lsz[$urandom_range(0, 4)] : $urandom_range(0, 2);
      a  = $urandom;
      if (sz == 1 || sz == 5) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      do_access("rnd", rd, wr, sz, a, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom);
    end
    for (int n = 0; n < 15; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      do_access("any", rd, wr, $urandom_range(0, 7), $urandom,
                $urandom, $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder-side counterpart of the core's decoded memory-control fields (mem_read, mem_write, mem_size = funct3).
- Turns a single-cycle core's load/store request into a valid/ready word-bus transaction and stalls the core until the transaction completes.
- Generates byte enables and replicated store data, and extracts plus sign- or zero-extends load data.
- Flags illegal or misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, maximum WAIT_RESP cycles before a fault is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  load request from control
- mem_write  in  1  store request from control
- mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load data, valid in the DONE cycle
- stall  out  1  core must hold PC and inputs while high
- lsu_fault  out  1  illegal, misaligned or timed-out access
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 00
- req_be  out  4  byte enables
- req_wdata  out  32  lane-positioned write data
- resp_valid  in  1  read data or write acknowledge
- resp_rdata  in  32  raw read word

Behaviour:
- States:
  - IDLE: no access in flight.
  - REQ: request presented, waiting for acceptance.
  - WAIT_RESP: request accepted, waiting for the response.
  - DONE: single completion cycle.
- Reset:
  - State goes to IDLE.
  - req_valid=0, req_we=0, req_be=0, req_addr=0, req_wdata=0.
  - rdata=0, lsu_fault=0, timeout counter=0.
  - stall=0 while in IDLE with no request.
- Access legality:
  - legal = exactly one of mem_read or mem_write is high, AND the size is valid, AND the access is aligned.
  - Valid sizes for stores: 000, 001, 010.
  - Valid sizes for loads: 000, 001, 010, 100, 101.
  - Aligned: H/HU need addr[0]=0; W needs addr[1:0]=00.
- IDLE with an access request:
  - Legal: stall=1 combinationally; latch req_we, req_addr, req_be, req_wdata, mem_size and addr[1:0]; go to REQ.
  - Illegal: lsu_fault=1 combinationally, stall=0, rdata=0, no bus activity, stay in IDLE.
- REQ: req_valid=1 and stall=1; payload held stable until req_ready; on req_ready go to WAIT_RESP.
- WAIT_RESP:
  - req_valid=0 and stall=1.
  - resp_valid is sampled only in this state; on resp_valid, register the extended data into rdata and go to DONE.
  - The counter increments every WAIT_RESP cycle. If it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES is not 0), go to DONE with lsu_fault registered high and rdata=0.
- DONE:
  - stall=0, so the core commits this cycle.
  - rdata and lsu_fault are registered values, held for this cycle only.
  - Next state is IDLE; the counter clears. IDLE does not accept a new access in the same cycle it is left.
- Latency (fast bus):
  - Cycle 0: IDLE, request seen.
  - Cycle 1: REQ, accepted.
  - Cycle 2: WAIT_RESP, resp_valid.
  - Cycle 3: DONE.
  - Minimum 4 cycles per access; extra req_ready or resp_valid wait cycles add 1:1.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1],0}.
  - W: 1111.
- Write data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes wdata through.
- Load extraction:
  - Shift resp_rdata right by addr[1:0]×8.
  - B/H: sign-extend bit 7 / bit 15.
  - BU/HU: zero-extend.
  - W: pass through.
- Writes still wait for resp_valid as an acknowledge; rdata=0 in the DONE cycle of a write.
- Stray resp_valid in IDLE, REQ or DONE is ignored.
- Reset mid-operation forces IDLE immediately; any outstanding bus response is later ignored.
- rdata and lsu_fault are 0 in every cycle other than DONE or the illegal-IDLE case.

Decomposition:
- Shared riscv package gains:
  - mem_size_t enum: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - lsu_state_t enum: IDLE, REQ, WAIT_RESP, DONE.
  - Bus request struct: we, addr, be, wdata.
- One natural sub-module, lsu_align: purely combinational lane steering, covering byte enables, write replication, and load extract/extend. It is reused by the future pipelined memory stage.
- The FSM, latches and timeout counter remain in load_store_unit.

Test Plan:
- LW at addr=0x100, req_ready=1, resp in the first WAIT cycle with data 0xDEADBEEF -> req_addr=0x100, req_be=1111; stall high for 3 cycles; rdata=0xDEADBEEF in DONE.
- LB at 0x103 with resp 0x80FF_FF7F -> req_be=1000, rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
- SH at addr 0x202, wdata=0x1234ABCD -> req_addr=0x200, req_be=1100, req_wdata=0xABCDABCD, req_we=1. DONE follows the ack.
- LW at 0x101 -> lsu_fault=1 and stall=0 in the same cycle; req_valid never asserts. Same result for mem_read=mem_write=1 and for mem_size=011.
- req_ready held low for 5 cycles -> req_valid and payload stay stable throughout; stall persists. With TIMEOUT_CYCLES=4 and no response -> DONE with lsu_fault=1 after 4 WAIT cycles.
- rst asserted during WAIT_RESP -> IDLE next edge with all outputs 0; a late resp_valid is ignored; a following LHU at 0x10 with resp 0x0000F00D -> rdata=0x0000F00D.
